// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for a 5-stage pipeline with load-use, branch and multi-cycle memory handling
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IFID_rs1,
  input  logic [4:0]  IFID_rs2,
  input  logic        IFID_uses_rs1,
  input  logic        IFID_uses_rs2,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rd,
  input  logic        EX_branch_taken,
  input  logic        EXMEM_MemRead,
  input  logic        EXMEM_MemWrite,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        pc_stall,
  output logic        IFID_stall,
  output logic        IFID_flush,
  output logic        IDEX_stall,
  output logic        IDEX_flush,
  output logic        EXMEM_stall,
  output logic        MEMWB_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt, cnt_n;
  logic             timeout_n, memop, err, mem_busy, hold, load_use, ack_ok;
  always_comb begin
    memop     = EXMEM_MemRead | EXMEM_MemWrite;
    err       = ~rst & (state == ERROR);
    dmem_req  = ~rst & (state != ERROR) & memop;
    ack_ok    = dmem_req & dmem_ack;
    mem_busy  = dmem_req & ~dmem_ack;
    hold      = mem_busy | err;
    load_use  = ~rst & IDEX_MemRead & (|IDEX_rd) &
                ((IFID_uses_rs1 & (IFID_rs1 == IDEX_rd)) | (IFID_uses_rs2 & (IFID_rs2 == IDEX_rd)));
    // a taken branch makes the ID instruction wrong-path, so it beats load-use
    pc_stall    = hold | (~EX_branch_taken & load_use);
    IFID_stall  = pc_stall;
    IDEX_stall  = hold;
    EXMEM_stall = hold;
    MEMWB_flush = rst | hold;
    IFID_flush  = rst | (~hold & EX_branch_taken);
    IDEX_flush  = rst | (~hold & (EX_branch_taken | load_use));
  end
  always_comb begin
    state_n   = state;
    cnt_n     = wait_cnt;
    timeout_n = mem_timeout;
    if (state == RUN && mem_busy) begin
      state_n = MEM_WAIT;
      cnt_n   = CNT_W'(1);
    end else if (state == MEM_WAIT) begin
      state_n   = ack_ok ? RUN : (wait_cnt == CNT_W'(TIMEOUT - 1)) ? ERROR : MEM_WAIT;
      cnt_n     = ack_ok ? '0 : wait_cnt + CNT_W'(1);
      timeout_n = mem_timeout | (~ack_ok & (wait_cnt == CNT_W'(TIMEOUT - 1)));
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= cnt_n;
      mem_timeout <= timeout_n;
      stall_cnt   <= (pc_stall && !(&stall_cnt)) ? stall_cnt + 32'd1 : stall_cnt;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard priority, memory wait, timeout and reset
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  IFID_rs1 = '0, IFID_rs2 = '0, IDEX_rd = '0;
  logic        IFID_uses_rs1 = 0, IFID_uses_rs2 = 0, IDEX_MemRead = 0, EX_branch_taken = 0;
  logic        EXMEM_MemRead = 0, EXMEM_MemWrite = 0, dmem_ack = 0;
  logic        dmem_req, pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush, mem_timeout;
  logic [31:0] stall_cnt, exp_cnt;
  logic [7:0]  ctl;
  int          n_cmp = 0, n_bad = 0;
  // ctl order: req, pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush
  localparam logic [7:0] NONE = 8'b0000_0000, RSTV = 8'b0001_0101, LU = 8'b0110_0100,
                         BR = 8'b0001_0100, WAIT = 8'b1110_1011, ACK = 8'b1000_0000,
                         ACKBR = 8'b1001_0100, ERR = 8'b0110_1011;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
    .IFID_uses_rs1(IFID_uses_rs1), .IFID_uses_rs2(IFID_uses_rs2),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd), .EX_branch_taken(EX_branch_taken),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_stall(pc_stall), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
    .IDEX_stall(IDEX_stall), .IDEX_flush(IDEX_flush), .EXMEM_stall(EXMEM_stall),
    .MEMWB_flush(MEMWB_flush), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt));
  assign ctl = {dmem_req, pc_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush, EXMEM_stall, MEMWB_flush};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // inputs are applied at a negedge; check, clock once, return at the next negedge
  task automatic cyc(input string tag, input logic [7:0] exp, input logic to);
    #1;
    chk({tag, ".ctl"}, {24'd0, ctl}, {24'd0, exp});
    chk({tag, ".cnt"}, stall_cnt, exp_cnt);
    chk({tag, ".to"}, {31'd0, mem_timeout}, {31'd0, to});
    @(posedge clk);
    if (exp[6]) exp_cnt = exp_cnt + 1;
    @(negedge clk);
  endtask
  task automatic clr();
    {IFID_uses_rs1, IFID_uses_rs2, IDEX_MemRead, EX_branch_taken, EXMEM_MemRead, EXMEM_MemWrite, dmem_ack} = '0;
    IFID_rs1 = '0; IFID_rs2 = '0; IDEX_rd = '0;
  endtask
  initial begin
    exp_cnt = 0;
    @(negedge clk);
    cyc("reset", RSTV, 1'b0);
    rst = 1'b0;
    cyc("idle", NONE, 1'b0);
    IDEX_MemRead = 1; IDEX_rd = 5; IFID_rs2 = 5; IFID_uses_rs2 = 1;
    cyc("lu_rs2", LU, 1'b0);
    IDEX_MemRead = 0;
    cyc("lu_bubble", NONE, 1'b0);
    IDEX_MemRead = 1; IDEX_rd = 0; IFID_rs2 = 0;
    cyc("lu_x0", NONE, 1'b0);
    clr(); IDEX_MemRead = 1; IDEX_rd = 9; IFID_rs1 = 9;
    cyc("lu_rs1_unused", NONE, 1'b0);
    IFID_uses_rs1 = 1;
    cyc("lu_rs1", LU, 1'b0);
    EX_branch_taken = 1;
    cyc("br_over_lu", BR, 1'b0);
    clr(); dmem_ack = 1;
    cyc("ack_no_req", NONE, 1'b0);
    clr(); EXMEM_MemRead = 1;
    cyc("wait0", WAIT, 1'b0);
    cyc("wait1", WAIT, 1'b0);
    cyc("wait2", WAIT, 1'b0);
    dmem_ack = 1;
    cyc("wait_ack", ACK, 1'b0);
    clr();
    cyc("after_ack", NONE, 1'b0);
    EXMEM_MemWrite = 1; dmem_ack = 1;
    cyc("zero_wait", ACK, 1'b0);
    clr();
    cyc("zero_wait_done", NONE, 1'b0);
    EXMEM_MemRead = 1; EX_branch_taken = 1;
    cyc("wbr0", WAIT, 1'b0);
    cyc("wbr1", WAIT, 1'b0);
    dmem_ack = 1;
    cyc("wbr_ack", ACKBR, 1'b0);
    clr(); EXMEM_MemRead = 1;
    cyc("to0", WAIT, 1'b0);
    cyc("to1", WAIT, 1'b0);
    cyc("to2", WAIT, 1'b0);
    cyc("to3", WAIT, 1'b0);
    cyc("err0", ERR, 1'b1);
    EX_branch_taken = 1; dmem_ack = 1;
    cyc("err1", ERR, 1'b1);
    clr();
    cyc("err2", ERR, 1'b1);
    rst = 1'b1; exp_cnt = 0;
    cyc("rst_err", RSTV, 1'b0);
    rst = 1'b0;
    cyc("rst_run", NONE, 1'b0);
    EXMEM_MemRead = 1;
    cyc("mw0", WAIT, 1'b0);
    cyc("mw1", WAIT, 1'b0);
    rst = 1'b1; exp_cnt = 0;
    cyc("rst_wait", RSTV, 1'b0);
    rst = 1'b0; dmem_ack = 1;
    cyc("post_rst_ack", ACK, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and taken branches/jumps resolved in EX.
- Sequences multi-cycle data-memory accesses through a req/ack handshake.
- When the pipeline stalls, inserts a bubble into MEM/WB so no write-back is repeated.

Parameters:
TIMEOUT, 200, consecutive no-ack cycles before the memory access is declared failed (>=2).
CNT_W, 8, width of the wait counter (2^CNT_W > TIMEOUT).

Ports:
clk  in  1  pipeline clock.
rst  in  1  reset, asynchronous, active-high.
IFID_rs1  in  5  rs1 of the instruction in ID.
IFID_rs2  in  5  rs2 of the instruction in ID.
IFID_uses_rs1  in  1  the ID instruction reads rs1.
IFID_uses_rs2  in  1  the ID instruction reads rs2.
IDEX_MemRead  in  1  the instruction in EX is a load.
IDEX_rd  in  5  destination register of the EX instruction.
EX_branch_taken  in  1  branch/jal/jalr in EX redirects the PC.
EXMEM_MemRead  in  1  the MEM-stage instruction reads data memory.
EXMEM_MemWrite  in  1  the MEM-stage instruction writes data memory.
dmem_ack  in  1  data memory has completed the access this cycle.
dmem_req  out  1  data-memory access request.
pc_stall  out  1  hold the PC.
IFID_stall  out  1  hold IF/ID.
IFID_flush  out  1  zero IF/ID (nop).
IDEX_stall  out  1  hold ID/EX.
IDEX_flush  out  1  zero ID/EX control signals.
EXMEM_stall  out  1  hold EX/MEM.
MEMWB_flush  out  1  load a bubble (RegWrite=0) into MEM/WB.
mem_timeout  out  1  sticky memory-failure flag.
stall_cnt  out  32  count of cycles with pc_stall=1.

Behaviour:
- Registered state: FSM state (RUN, MEM_WAIT, ERROR), wait_cnt, mem_timeout, stall_cnt. All control outputs are combinational from the state and the inputs.
- Reset (rst=1, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0.
  - While rst=1: IFID_flush=IDEX_flush=MEMWB_flush=1; all other control outputs 0; dmem_req=0.
- memop = EXMEM_MemRead | EXMEM_MemWrite.
- dmem_req = memop in RUN and MEM_WAIT; 0 in ERROR.
  - Stays high until the cycle dmem_ack=1 is seen.
  - dmem_ack is ignored whenever dmem_req=0.
- mem_busy = dmem_req & ~dmem_ack. It is asserted in the same cycle the ack is missing, so a zero-wait memory (ack in the request cycle) costs no stall.
- FSM transitions:
  - RUN: if mem_busy, go to MEM_WAIT and set wait_cnt=1; otherwise stay in RUN.
  - MEM_WAIT: if dmem_ack, go to RUN and clear wait_cnt.
  - MEM_WAIT: else if wait_cnt==TIMEOUT-1, go to ERROR and set mem_timeout=1.
  - MEM_WAIT: otherwise increment wait_cnt.
  - ERROR: held until rst. In ERROR: pc_stall, IFID_stall, IDEX_stall and EXMEM_stall are 1; MEMWB_flush=1; dmem_req=0.
- Output priority (highest first):
  1. mem_busy or ERROR: pc_stall=IFID_stall=IDEX_stall=EXMEM_stall=1, MEMWB_flush=1, all other flushes 0. Branch and load-use are deferred because ID/EX is frozen; they re-evaluate after release.
  2. EX_branch_taken: IFID_flush=IDEX_flush=1, no stalls. This overrides load-use, since the ID instruction is wrong-path.
  3. Load-use: IDEX_MemRead & IDEX_rd!=0 & ((IFID_uses_rs1 & IFID_rs1==IDEX_rd) | (IFID_uses_rs2 & IFID_rs2==IDEX_rd)). Response: pc_stall=IFID_stall=1, IDEX_flush=1. This gives exactly one bubble; the following cycle is resolved by forwarding.
  4. Otherwise all outputs are 0.
- Cycle with dmem_ack in MEM_WAIT:
  - All stalls and MEMWB_flush are 0.
  - MEM/WB captures the load data.
  - Branch and load-use rules apply in that same cycle.
- stall_cnt increments every cycle pc_stall=1, including ERROR. It saturates at 32'hFFFF_FFFF.
- Reset mid-wait: returns to RUN immediately and dmem_req drops. The memory side must tolerate an abandoned request.

Test Plan:
1. Load-use: lw x5 in EX (IDEX_MemRead=1, IDEX_rd=5), add in ID with IFID_rs2=5, uses_rs2=1 -> one cycle of pc_stall=IFID_stall=IDEX_flush=1, then all 0. Repeat with IDEX_rd=0 -> no stall.
2. Branch vs load-use: load-use condition plus EX_branch_taken=1 in the same cycle -> IFID_flush=IDEX_flush=1, pc_stall=0.
3. Memory wait: EXMEM_MemRead=1, dmem_ack arriving 3 cycles after the request -> dmem_req high for 4 cycles; stalls and MEMWB_flush high for 3 cycles and low in the ack cycle; stall_cnt=3. Zero-wait ack -> no stall.
4. Wait masks branch: EX_branch_taken=1 during MEM_WAIT -> no flush until the ack cycle, then IFID_flush=IDEX_flush=1 in the ack cycle.
5. Timeout: TIMEOUT=4, never ack -> ERROR entered after 4 no-ack cycles; mem_timeout=1 sticky, dmem_req=0, all stalls held. Assert rst mid-ERROR -> RUN, mem_timeout=0, stall_cnt=0 asynchronously.
